// File: rtl/rv_mem_pkg.sv
// Shared opcode/funct3 constants, FSM encoding and lane helpers for the
// memory-access stage.
package rv_mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Unlisted funct3 values behave as word accesses for both loads and stores.
  function automatic logic is_misaligned(input logic [6:0] op,
                                         input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (op == OP_LOAD) begin
      case (f3)
        F3_B, F3_BU: mis = 1'b0;
        F3_H, F3_HU: mis = lo[0];
        default:     mis = (lo != 2'b00);
      endcase
    end else if (op == OP_STORE) begin
      case (f3)
        F3_B:    mis = 1'b0;
        F3_H:    mis = lo[0];
        default: mis = (lo != 2'b00);
      endcase
    end else begin
      mis = 1'b0;
    end
    return mis;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lo;
      F3_H:    be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [31:0] word,
                                              input logic [1:0]  lo);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res;
    byte_s = word[{lo, 3'b000} +: 8];
    half_s = word[{lo[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    res = {{24{byte_s[7]}}, byte_s};
      F3_BU:   res = {24'h000000, byte_s};
      F3_H:    res = {{16{half_s[15]}}, half_s};
      F3_HU:   res = {16'h0000, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port DEPTH_WORDS x 32 data RAM with per-byte write enables and a
// registered read port. Contents are intentionally not reset.
module data_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [0:DEPTH_WORDS-1];
  logic [31:0] rdata_r;

  assign rdata = rdata_r;

  // Byte-lane write and registered read (old data on a simultaneous write).
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata_r <= mem_r[addr];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V memory-access stage: captures one instruction, performs the load or
// store against the local data RAM and hands a registered bundle to write-back.
module mem_access_stage
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] pc_plus4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] C,
  output logic [6:0]  out_opcode,
  output logic        out_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t         state_r;
  state_t         next_state_s;

  logic [6:0]     op_r;
  logic [2:0]     f3_r;
  logic [AW+1:0]  addr_r;
  logic [31:0]    sd_r;

  logic [31:0]    a_r;
  logic [31:0]    b_r;
  logic [31:0]    c_r;
  logic [6:0]     opc_r;
  logic           err_r;
  logic           out_valid_r;

  logic           accept_s;
  logic           is_mem_s;
  logic           mis_s;

  logic           ram_en_s;
  logic [3:0]     ram_we_s;
  logic [AW-1:0]  ram_addr_s;
  logic [31:0]    ram_wdata_s;
  logic [31:0]    ram_rdata_s;

  assign accept_s = in_valid && (state_r == IDLE);
  assign is_mem_s = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign mis_s    = is_misaligned(opcode, funct3, alu_result[1:0]);

  assign in_ready   = (state_r == IDLE) && !rst;
  assign out_valid  = out_valid_r;
  assign A          = a_r;
  assign B          = b_r;
  assign C          = c_r;
  assign out_opcode = opc_r;
  assign out_err    = err_r;

  // State register; out_valid is registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s == RESP);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (is_mem_s && !mis_s) begin
            next_state_s = ACCESS;
          end else begin
            next_state_s = RESP;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: next_state_s = RESP;
      RESP: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // RAM port control: the load read is launched on the accept edge so the
  // word sits in the RAM output register during ACCESS; stores write in ACCESS.
  always_comb begin
    ram_en_s    = 1'b0;
    ram_we_s    = 4'b0000;
    ram_addr_s  = alu_result[AW+1:2];
    ram_wdata_s = sd_r << {addr_r[1:0], 3'b000};
    case (state_r)
      IDLE: begin
        if (accept_s && (opcode == OP_LOAD) && !mis_s) begin
          ram_en_s = 1'b1;
        end else begin
          ram_en_s = 1'b0;
        end
      end
      ACCESS: begin
        ram_addr_s = addr_r[AW+1:2];
        if (op_r == OP_STORE) begin
          ram_en_s = 1'b1;
          ram_we_s = store_lanes(f3_r, addr_r[1:0]);
        end else begin
          ram_en_s = 1'b0;
        end
      end
      default: begin
        ram_en_s = 1'b0;
      end
    endcase
  end

  // Instruction capture for the ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= 7'd0;
      f3_r   <= 3'd0;
      addr_r <= '0;
      sd_r   <= 32'd0;
    end else if (accept_s) begin
      op_r   <= opcode;
      f3_r   <= funct3;
      addr_r <= alu_result[AW+1:0];
      sd_r   <= store_data;
    end
  end

  // Write-back bundle; B is filled with the extended load data leaving ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      c_r   <= 32'd0;
      opc_r <= 7'd0;
      err_r <= 1'b0;
    end else if (accept_s) begin
      a_r   <= alu_result;
      b_r   <= 32'd0;
      c_r   <= pc_plus4;
      opc_r <= opcode;
      err_r <= is_mem_s && mis_s;
    end else if ((state_r == ACCESS) && (op_r == OP_LOAD)) begin
      b_r <= load_extend(f3_r, ram_rdata_s, addr_r[1:0]);
    end
  end

  data_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_data_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random
// traffic checked against a byte-array memory model.
module tb_mem_access_stage;
  import rv_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int BYTES = 4 * DEPTH;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [31:0] pc_plus4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] C;
  logic [6:0]  out_opcode;
  logic        out_err;

  int vectors;
  int miscompares;

  logic [7:0] mem_m [0:BYTES-1];

  mem_access_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .alu_result(alu_result),
    .store_data(store_data), .pc_plus4(pc_plus4), .out_valid(out_valid),
    .out_ready(out_ready), .A(A), .B(B), .C(C), .out_opcode(out_opcode),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Reference: access size from funct3, misalignment as addr mod size, bytes
  // read/written in a flat byte array wrapping at the RAM size.
  task automatic model(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       output logic [31:0] eb, output logic ee, output int el);
    int size;
    int base;
    logic [31:0] val;
    eb = 32'd0; ee = 1'b0; el = 1;
    if (op != OP_LOAD && op != OP_STORE) return;
    if (f3 == F3_B || (op == OP_LOAD && f3 == F3_BU)) size = 1;
    else if (f3 == F3_H || (op == OP_LOAD && f3 == F3_HU)) size = 2;
    else size = 4;
    if ((addr % size) != 0) begin
      ee = 1'b1;
      return;
    end
    el = 2;
    base = int'(addr % BYTES);
    if (op == OP_STORE) begin
      for (int i = 0; i < size; i++) mem_m[base + i] = 8'((sd >> (8 * i)) & 32'hFF);
    end else begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val = val | (32'(mem_m[base + i]) << (8 * i));
      if (f3 == F3_B && val[7]) val = val | 32'hFFFF_FF00;
      if (f3 == F3_H && val[15]) val = val | 32'hFFFF_0000;
      eb = val;
    end
  endtask

  // Drives one instruction, returns the sampled bundle, latency and whether
  // the bundle stayed put (with in_ready low) during `hold` stalled cycles.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] pc, input int hold,
                        output logic [31:0] a_o, output logic [31:0] b_o,
                        output logic [31:0] c_o, output logic [6:0] opc_o,
                        output logic err_o, output int lat_o, output bit held_ok);
    bit got;
    lat_o = -1; held_ok = 1'b0;
    a_o = 'x; b_o = 'x; c_o = 'x; opc_o = 'x; err_o = 1'bx;
    @(negedge clk);
    opcode = op; funct3 = f3; alu_result = addr; store_data = sd; pc_plus4 = pc;
    in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin in_valid = 1'b0; return; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (hold == 0) out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin lat_o = k; break; end
    end
    if (lat_o < 0) begin out_ready = 1'b0; return; end
    a_o = A; b_o = B; c_o = C; opc_o = out_opcode; err_o = out_err;
    held_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!out_valid || in_ready || A !== a_o || B !== b_o || C !== c_o ||
          out_opcode !== opc_o || out_err !== err_o) held_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    alu_result = 32'd0; store_data = 32'd0; pc_plus4 = 32'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
    end
    vectors++;
    if (A !== 32'd0 || B !== 32'd0 || C !== 32'd0 || out_opcode !== 7'd0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: A=%h B=%h C=%h op=%h err=%b, required all 0", A, B, C, out_opcode, out_err);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  // Gives every RAM word a known random value so later loads are defined.
  task automatic test_fill();
    logic [31:0] a, b, c, eb, sd; logic [6:0] oc; logic e, ee; int lat, el; bit h;
    for (int w = 0; w < DEPTH; w++) begin
      sd = $urandom;
      model(OP_STORE, F3_W, 32'(w * 4), sd, eb, ee, el);
      run_op(OP_STORE, F3_W, 32'(w * 4), sd, 32'h100, 0, a, b, c, oc, e, lat, h);
      vectors++;
      if (b !== eb || e !== ee || lat != el) begin
        miscompares++;
        $display("FAIL fill[%0d]: B=%h err=%b lat=%0d, required %h/%b/%0d", w, b, e, lat, eb, ee, el);
      end
    end
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [31:0] addr; logic [31:0] sd;
    logic [31:0] pc; logic [31:0] eb; logic ee; int el; int hold;
  } dvec_t;

  task automatic test_directed();
    dvec_t t [14];
    logic [31:0] a, b, c, mb; logic [6:0] oc; logic e, me; int lat, ml; bit h;
    t[0]  = '{OP_STORE, F3_W,  32'h10,  32'hDEADBEEF, 32'h04, 32'h0,        1'b0, 2, 0};
    t[1]  = '{OP_LOAD,  F3_W,  32'h10,  32'h0,        32'h08, 32'hDEADBEEF, 1'b0, 2, 0};
    t[2]  = '{OP_STORE, F3_B,  32'h13,  32'h80,       32'h0C, 32'h0,        1'b0, 2, 0};
    t[3]  = '{OP_LOAD,  F3_B,  32'h13,  32'h0,        32'h10, 32'hFFFFFF80, 1'b0, 2, 1};
    t[4]  = '{OP_LOAD,  F3_BU, 32'h13,  32'h0,        32'h14, 32'h00000080, 1'b0, 2, 0};
    t[5]  = '{OP_LOAD,  F3_W,  32'h10,  32'h0,        32'h18, 32'h80ADBEEF, 1'b0, 2, 0};
    t[6]  = '{OP_LOAD,  F3_H,  32'h11,  32'h0,        32'h1C, 32'h0,        1'b1, 1, 0};
    t[7]  = '{OP_LOAD,  F3_W,  32'h10,  32'h0,        32'h20, 32'h80ADBEEF, 1'b0, 2, 0};
    t[8]  = '{OP_ADD,   3'd0,  32'h10,  32'h55,       32'h30, 32'h0,        1'b0, 1, 3};
    t[9]  = '{OP_STORE, F3_W,  32'h400, 32'h12345678, 32'h34, 32'h0,        1'b0, 2, 0};
    t[10] = '{OP_LOAD,  F3_W,  32'h000, 32'h0,        32'h38, 32'h12345678, 1'b0, 2, 0};
    t[11] = '{OP_STORE, F3_H,  32'h22,  32'hAAAA8001, 32'h3C, 32'h0,        1'b0, 2, 0};
    t[12] = '{OP_LOAD,  F3_H,  32'h22,  32'h0,        32'h40, 32'hFFFF8001, 1'b0, 2, 0};
    t[13] = '{OP_LOAD,  F3_HU, 32'h22,  32'h0,        32'h44, 32'h00008001, 1'b0, 2, 2};
    for (int i = 0; i < 14; i++) begin
      model(t[i].op, t[i].f3, t[i].addr, t[i].sd, mb, me, ml);
      run_op(t[i].op, t[i].f3, t[i].addr, t[i].sd, t[i].pc, t[i].hold, a, b, c, oc, e, lat, h);
      vectors++;
      if (a !== t[i].addr || b !== t[i].eb || c !== t[i].pc || oc !== t[i].op ||
          e !== t[i].ee || lat != t[i].el) begin
        miscompares++;
        $display("FAIL directed[%0d]: A=%h B=%h C=%h op=%h err=%b lat=%0d, required %h/%h/%h/%h/%b/%0d",
                 i, a, b, c, oc, e, lat, t[i].addr, t[i].eb, t[i].pc, t[i].op, t[i].ee, t[i].el);
      end
      if (t[i].hold > 0) begin
        vectors++;
        if (h !== 1'b1) begin
          miscompares++;
          $display("FAIL directed_hold[%0d]: stable=%b, required 1", i, h);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, c, eb; logic [6:0] oc; logic e, ee; int lat, el; bit h;
    // Store aborted in ACCESS.
    @(negedge clk);
    opcode = OP_STORE; funct3 = F3_W; alu_result = 32'h20; store_data = 32'hFFFFFFFF;
    pc_plus4 = 32'h50; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || A !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_access: out_valid=%b in_ready=%b A=%h, required 0/0/0", out_valid, in_ready, A);
    end
    @(negedge clk);
    rst = 1'b0;
    model(OP_LOAD, F3_W, 32'h20, 32'h0, eb, ee, el);
    run_op(OP_LOAD, F3_W, 32'h20, 32'h0, 32'h54, 0, a, b, c, oc, e, lat, h);
    vectors++;
    if (b !== eb || e !== 1'b0 || lat != 2) begin
      miscompares++;
      $display("FAIL rst_nowrite: B=%h err=%b lat=%0d, required %h/0/2", b, e, lat, eb);
    end
    // Pending bundle dropped.
    @(negedge clk);
    opcode = OP_ADD; funct3 = 3'd0; alu_result = 32'h77; pc_plus4 = 32'h58; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || A !== 32'h77) begin
      miscompares++;
      $display("FAIL resp_before_rst: out_valid=%b A=%h, required 1/00000077", out_valid, A);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || A !== 32'd0 || C !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_resp: out_valid=%b A=%h C=%h, required 0/0/0", out_valid, A, C);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, b, c, eb, addr, sd, pc; logic [6:0] op, oc; logic [2:0] f3;
    logic e, ee; int lat, el, hold, r; bit h;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = OP_LOAD;
      else if (r < 8) op = OP_STORE;
      else if (r == 8) op = OP_ADD;
      else op = 7'b0010011;
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      sd = $urandom;
      pc = $urandom;
      hold = $urandom_range(0, 2);
      model(op, f3, addr, sd, eb, ee, el);
      run_op(op, f3, addr, sd, pc, hold, a, b, c, oc, e, lat, h);
      vectors++;
      if (a !== addr || b !== eb || c !== pc || oc !== op || e !== ee || lat != el ||
          (hold > 0 && h !== 1'b1)) begin
        miscompares++;
        $display("FAIL random[%0d] op=%h f3=%0d addr=%h: A=%h B=%h C=%h op=%h err=%b lat=%0d held=%b, required %h/%h/%h/%h/%b/%0d/1",
                 n, op, f3, addr, a, b, c, oc, e, lat, h, addr, eb, pc, op, ee, el);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fill();
    test_directed();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
